// File: rtl/pc_irq_unit.sv
// Program counter with vectored, edge-triggered interrupts, exception entry and eret.
// Supervisor mode is ia[WIDTH-1]; interrupts are taken only from user mode.
module pc_irq_unit #(
  parameter int unsigned           WIDTH      = 32,
  parameter int unsigned           NIRQ       = 4,
  parameter logic [WIDTH-1:0]      RESET_VEC  = 32'h8000_0000,
  parameter logic [WIDTH-1:0]      EXC_VEC    = 32'h8000_0004,
  parameter logic [WIDTH-1:0]      IRQ_BASE   = 32'h8000_0008,
  parameter int unsigned           IRQ_STRIDE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [WIDTH-1:0] pcin,
  input  logic             exception,
  input  logic             eret,
  input  logic [NIRQ-1:0]  irq,
  input  logic [NIRQ-1:0]  irq_en,
  output logic [WIDTH-1:0] ia,
  output logic [WIDTH-1:0] xp,
  output logic [NIRQ-1:0]  irq_pending,
  output logic [NIRQ-1:0]  irq_ack,
  output logic [15:0]      irq_count
);

  localparam int unsigned KW = (NIRQ > 1) ? $clog2(NIRQ) : 1;

  logic [NIRQ-1:0]  irq_prev;
  logic [NIRQ-1:0]  eligible;
  logic [NIRQ-1:0]  rise;
  logic [NIRQ-1:0]  take_mask;
  logic [KW-1:0]    sel;
  logic             take;
  logic [WIDTH-1:0] ia_next;
  logic [WIDTH-1:0] xp_next;
  logic [WIDTH-1:0] irq_vec;
  logic [WIDTH-1:0] ia_plus4;

  assign eligible = irq_pending & irq_en;
  assign rise     = irq & ~irq_prev;
  assign take     = ~stall && (eligible != '0) && ~ia[WIDTH-1];
  assign ia_plus4 = ia + WIDTH'(4);
  assign irq_vec  = IRQ_BASE + WIDTH'(sel) * WIDTH'(IRQ_STRIDE);

  // Lowest eligible index wins; scanning downward leaves the lowest one selected.
  always_comb begin
    sel = '0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (eligible[i]) sel = KW'(i);
    end
  end

  always_comb begin
    take_mask = '0;
    if (take) take_mask[sel] = 1'b1;
  end

  // Next ia/xp: irq beats exception beats supervisor eret beats sequential flow.
  always_comb begin
    ia_next = ia;
    xp_next = xp;
    if (!stall) begin
      if (take) begin
        ia_next = irq_vec;
        xp_next = ia_plus4;
      end else if (exception) begin
        ia_next = EXC_VEC;
        xp_next = ia_plus4;
      end else if (eret && ia[WIDTH-1]) begin
        ia_next = xp;
      end else begin
        ia_next = pcin;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ia          <= RESET_VEC;
      xp          <= '0;
      irq_prev    <= '0;
      irq_pending <= '0;
      irq_ack     <= '0;
      irq_count   <= '0;
    end else begin
      irq_prev    <= irq;
      // A new edge on a line being taken keeps it pending.
      irq_pending <= (irq_pending & ~take_mask) | rise;
      irq_ack     <= take_mask;
      ia          <= ia_next;
      xp          <= xp_next;
      if (take && irq_count != 16'hFFFF) irq_count <= irq_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_pc_irq_unit.sv
// Directed bench for pc_irq_unit: sequencing, irq priority/masking, exception, eret, stall, async reset.
module tb_pc_irq_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [31:0] pcin;
  logic        exception;
  logic        eret;
  logic [3:0]  irq;
  logic [3:0]  irq_en;
  logic [31:0] ia;
  logic [31:0] xp;
  logic [3:0]  irq_pending;
  logic [3:0]  irq_ack;
  logic [15:0] irq_count;

  int n_cmp = 0;
  int n_err = 0;

  pc_irq_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .pcin(pcin),
    .exception(exception), .eret(eret), .irq(irq), .irq_en(irq_en),
    .ia(ia), .xp(xp), .irq_pending(irq_pending), .irq_ack(irq_ack),
    .irq_count(irq_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_ia, input logic [31:0] e_xp,
                         input logic [3:0] e_pend, input logic [3:0] e_ack, input logic [15:0] e_cnt);
    chk({tag, ".ia"},   ia, e_ia);
    chk({tag, ".xp"},   xp, e_xp);
    chk({tag, ".pend"}, 32'(irq_pending), 32'(e_pend));
    chk({tag, ".ack"},  32'(irq_ack), 32'(e_ack));
    chk({tag, ".cnt"},  32'(irq_count), 32'(e_cnt));
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; pcin = 32'h0; exception = 1'b0; eret = 1'b0;
    irq = 4'h0; irq_en = 4'hF;
    step(); step();
    reset = 1'b0;
    chk_all("reset", 32'h8000_0000, 32'h0, 4'h0, 4'h0, 16'd0);

    // Sequential flow
    pcin = 32'h100; step();
    chk_all("seq0", 32'h100, 32'h0, 4'h0, 4'h0, 16'd0);
    pcin = 32'h104; step();
    chk_all("seq1", 32'h104, 32'h0, 4'h0, 4'h0, 16'd0);

    // Single irq on line 2 from ia=0x100
    pcin = 32'h100; step();
    irq = 4'b0100; step();
    chk_all("irq2_pend", 32'h100, 32'h0, 4'b0100, 4'h0, 16'd0);
    step();
    chk_all("irq2_take", 32'h8000_0010, 32'h104, 4'h0, 4'b0100, 16'd1);

    // Two simultaneous edges: line 1 first, line 3 waits for user mode
    irq = 4'h0; pcin = 32'h200; step();
    chk_all("to200", 32'h200, 32'h104, 4'h0, 4'h0, 16'd1);
    irq = 4'b1010; step();
    chk_all("irq13_pend", 32'h200, 32'h104, 4'b1010, 4'h0, 16'd1);
    step();
    chk_all("irq1_take", 32'h8000_000C, 32'h204, 4'b1000, 4'b0010, 16'd2);
    pcin = 32'h8000_0010; step();
    chk_all("sup_hold3", 32'h8000_0010, 32'h204, 4'b1000, 4'h0, 16'd2);
    eret = 1'b1; step();
    chk_all("eret", 32'h204, 32'h204, 4'b1000, 4'h0, 16'd2);
    eret = 1'b0; pcin = 32'h208; step();
    chk_all("irq3_take", 32'h8000_0014, 32'h208, 4'h0, 4'b1000, 16'd3);

    // Exception coinciding with an eligible irq in user mode: irq wins
    irq = 4'h0; pcin = 32'h300; step();
    irq = 4'b0001; step();
    chk_all("to300", 32'h300, 32'h208, 4'b0001, 4'h0, 16'd3);
    exception = 1'b1; step();
    chk_all("irq_beats_exc", 32'h8000_0008, 32'h304, 4'h0, 4'b0001, 16'd4);

    // Exception in supervisor with an irq pending
    exception = 1'b0; irq = 4'h0; pcin = 32'h8000_0040; step();
    irq = 4'b0100; step();
    chk_all("sup40", 32'h8000_0040, 32'h304, 4'b0100, 4'h0, 16'd4);
    exception = 1'b1; step();
    chk_all("exc_sup", 32'h8000_0004, 32'h8000_0044, 4'b0100, 4'h0, 16'd4);

    // Masked line stays pending in user mode until enabled
    exception = 1'b0; irq_en = 4'h0; pcin = 32'h400; step();
    pcin = 32'h404; step();
    chk_all("masked", 32'h404, 32'h8000_0044, 4'b0100, 4'h0, 16'd4);
    irq_en = 4'hF; step();
    chk_all("unmask_take", 32'h8000_0010, 32'h408, 4'h0, 4'b0100, 16'd5);

    // Stall: ia/xp/count frozen, ack low, capture continues, exception ignored
    irq = 4'h0; pcin = 32'h500; step();
    stall = 1'b1; pcin = 32'h600; step();
    chk_all("stall1", 32'h500, 32'h408, 4'h0, 4'h0, 16'd5);
    irq = 4'b0001; step();
    chk_all("stall2", 32'h500, 32'h408, 4'b0001, 4'h0, 16'd5);
    exception = 1'b1; step();
    chk_all("stall3", 32'h500, 32'h408, 4'b0001, 4'h0, 16'd5);
    exception = 1'b0; stall = 1'b0; step();
    chk_all("unstall_take", 32'h8000_0008, 32'h504, 4'h0, 4'b0001, 16'd6);

    // eret in user mode is ignored
    pcin = 32'h700; step();
    eret = 1'b1; pcin = 32'h704; step();
    chk_all("eret_user", 32'h704, 32'h504, 4'h0, 4'h0, 16'd6);
    eret = 1'b0;

    // Asynchronous reset between edges with lines pending
    irq_en = 4'h0; irq = 4'b1010; step();
    chk("pend_pre_rst", 32'(irq_pending), 32'(4'b1010));
    #2 reset = 1'b1;
    #1;
    chk_all("async_rst", 32'h8000_0000, 32'h0, 4'h0, 4'h0, 16'd0);
    #1 reset = 1'b0;
    step();
    chk_all("post_rst_edge", 32'h704, 32'h0, 4'b1010, 4'h0, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
